// File: rtl/axi_rd_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_slave_if
// Brief    : AXI read-address / read-data channel bundle for axi_rd_slave.
// Revision : 1.0
// ============================================================================
interface axi_rd_slave_if;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [2:0]  ARPORT;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPORT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPORT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_slave
// Brief    : Single-outstanding AXI read slave over a 1-cycle synchronous memory.
//            Define AXI_RD_SLV_WRAP_EN to support WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi_rd_slave #(
  parameter logic [63:0] ADDR_LO = 64'h0000_0000_8000_0000,
  parameter logic [63:0] ADDR_HI = 64'h0000_0000_87FF_FFFF,
  parameter int unsigned RD_LAT  = 0
) (
  input  wire logic        clk,
  input  wire logic        rstn,
  axi_rd_slave_if.slave    axi,
  output logic             mem_ren,
  output logic [63:0]      mem_raddr,
  input  wire logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_READ = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam bit         HAS_WAIT  = (RD_LAT != 0);
  localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 1);

  state_t      state, next_state;
  logic        ready_en;
  logic        arready;
  logic [3:0]  id_q;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        slverr_q;
  logic [7:0]  beat_cnt;
  logic [3:0]  wait_cnt;
  logic [3:0]  rid_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic        rvalid_q;

  logic        ar_fire, r_fire, last_beat;
  logic [16:0] ar_bytes, ar_end;
  logic        ar_cross, ar_slverr;
  logic [63:0] step, next_addr;
  logic        beat_outside;
  logic [1:0]  beat_resp;
  logic        unused_arport;

`ifdef AXI_RD_SLV_WRAP_EN
  logic [63:0] wrap_mask_q;
  logic [3:0]  align_mask;
`endif

  assign unused_arport = ^axi.ARPORT;
  assign ar_fire       = axi.ARVALID & arready;
  assign r_fire        = rvalid_q & axi.RREADY;
  assign last_beat     = (beat_cnt == len_q);

  // Burst-wide SLVERR is decided once, from the AR payload, at acceptance.
  always_comb begin
    ar_bytes  = ({9'd0, axi.ARLEN} + 17'd1) << axi.ARSIZE;
    ar_end    = {5'd0, axi.ARADDR[11:0]} + ar_bytes;
    ar_cross  = (ar_end > 17'd4096);
`ifdef AXI_RD_SLV_WRAP_EN
    align_mask = 4'((4'd1 << axi.ARSIZE) - 4'd1);
`endif
    ar_slverr = 1'b1;
    case (axi.ARBURST)
      2'b00:   ar_slverr = (axi.ARSIZE > 3'd3);
      2'b01:   ar_slverr = (axi.ARSIZE > 3'd3) || ar_cross;
`ifdef AXI_RD_SLV_WRAP_EN
      2'b10:   ar_slverr = (axi.ARSIZE > 3'd3)
                        || !((axi.ARLEN == 8'd1) || (axi.ARLEN == 8'd3)
                          || (axi.ARLEN == 8'd7) || (axi.ARLEN == 8'd15))
                        || (({1'b0, axi.ARADDR[2:0]} & align_mask) != 4'd0);
`endif
      default: ar_slverr = 1'b1;
    endcase
  end

  always_comb begin
    step         = 64'd1 << size_q;
    beat_outside = (addr_q < ADDR_LO) || (addr_q > ADDR_HI);
    beat_resp    = slverr_q ? 2'b10 : (beat_outside ? 2'b11 : 2'b00);
    case (burst_q)
      2'b00:   next_addr = addr_q;
`ifdef AXI_RD_SLV_WRAP_EN
      2'b10:   next_addr = (addr_q & ~wrap_mask_q) | ((addr_q + step) & wrap_mask_q);
`endif
      default: next_addr = addr_q + step;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    arready    = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = 64'd0;
    case (state)
      ST_IDLE: begin
        arready = ready_en;
        if (axi.ARVALID && ready_en) next_state = HAS_WAIT ? ST_WAIT : ST_READ;
      end
      ST_WAIT: if (wait_cnt == WAIT_LAST) next_state = ST_READ;
      ST_READ: begin
        if (beat_resp == 2'b00) begin
          mem_ren   = 1'b1;
          mem_raddr = {addr_q[63:3], 3'b000};
        end
        next_state = ST_CAPT;
      end
      ST_CAPT: next_state = ST_RESP;
      ST_RESP: if (r_fire) next_state = last_beat ? ST_IDLE : (HAS_WAIT ? ST_WAIT : ST_READ);
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en <= 1'b0;
      id_q     <= 4'd0;
      addr_q   <= 64'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
      slverr_q <= 1'b0;
      beat_cnt <= 8'd0;
      wait_cnt <= 4'd0;
      rid_q    <= 4'd0;
      rdata_q  <= 64'd0;
      rresp_q  <= 2'd0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
`ifdef AXI_RD_SLV_WRAP_EN
      wrap_mask_q <= 64'd0;
`endif
    end else begin
      ready_en <= 1'b1;
      wait_cnt <= 4'd0;
      case (state)
        ST_IDLE: if (ar_fire) begin
          id_q     <= axi.ARID;
          addr_q   <= axi.ARADDR;
          len_q    <= axi.ARLEN;
          size_q   <= axi.ARSIZE;
          burst_q  <= axi.ARBURST;
          slverr_q <= ar_slverr;
          beat_cnt <= 8'd0;
`ifdef AXI_RD_SLV_WRAP_EN
          wrap_mask_q <= 64'(ar_bytes) - 64'd1;
`endif
        end
        ST_WAIT: wait_cnt <= wait_cnt + 4'd1;
        ST_CAPT: begin
          rdata_q  <= (beat_resp == 2'b00) ? mem_rdata : 64'd0;
          rresp_q  <= beat_resp;
          rlast_q  <= last_beat;
          rid_q    <= id_q;
          rvalid_q <= 1'b1;
        end
        ST_RESP: if (r_fire) begin
          rvalid_q <= 1'b0;
          if (last_beat) begin
            // Return the R channel to its reset image while idle.
            rid_q    <= 4'd0;
            rdata_q  <= 64'd0;
            rresp_q  <= 2'd0;
            rlast_q  <= 1'b0;
            beat_cnt <= 8'd0;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            addr_q   <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign axi.ARREADY = arready;
  assign axi.RID     = rid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RVALID  = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_slave
// Brief    : Scoreboard bench for axi_rd_slave (RD_LAT=2) with a 1-cycle memory model.
// Revision : 1.0
// ============================================================================
module tb_axi_rd_slave;
  localparam int          LAT = 2;
  localparam logic [63:0] LO  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HI  = 64'h0000_0000_87FF_FFFF;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_ren;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata = 64'd0;

  axi_rd_slave_if axi();

  axi_rd_slave #(.ADDR_LO(LO), .ADDR_HI(HI), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .axi       (axi),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc = 0, ref_cyc = 0;
  int    hs_count = 0, hs_limit = 1 << 30;
  int    rdy_mode = 0;
  logic  tog = 1'b0;
  logic  prev_valid = 1'b0, hold_pend = 1'b0;
  logic [63:0] held_data;
  logic [6:0]  held_ctl;
  beat_t mon_b;
  beat_t exp_r[$];
  logic [63:0] exp_m[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] memf(input logic [63:0] a);
    return {~a[31:0], a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  always @(posedge clk) if (mem_ren) mem_rdata <= memf(mem_raddr);

  task automatic push_expect(input logic [3:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
    logic        slv;
    logic [16:0] span;
    logic [63:0] a, stepv, win;
    beat_t       b;
    span  = (17'(len) + 17'd1) << size;
    stepv = 64'd1 << size;
    win   = 64'(span);
    case (burst)
      2'b00: slv = (size > 3'd3);
      2'b01: slv = (size > 3'd3) || (({5'd0, addr[11:0]} + span) > 17'd4096);
`ifdef AXI_RD_SLV_WRAP_EN
      2'b10: slv = (size > 3'd3) || !(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr % stepv) != 64'd0);
`endif
      default: slv = 1'b1;
    endcase
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      if (slv)                   b.resp = 2'b10;
      else if (a < LO || a > HI) b.resp = 2'b11;
      else                       b.resp = 2'b00;
      b.data = (b.resp == 2'b00) ? memf({a[63:3], 3'b000}) : 64'd0;
      if (b.resp == 2'b00) exp_m.push_back({a[63:3], 3'b000});
      exp_r.push_back(b);
      if (burst == 2'b01)      a = a + stepv;
      else if (burst == 2'b10) a = (a & ~(win - 64'd1)) | ((a + stepv) & (win - 64'd1));
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    push_expect(id, addr, len, size, burst);
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size;
    axi.ARBURST = burst; axi.ARPORT = 3'($urandom); axi.ARVALID = 1'b1;
    @(negedge clk);
    while (!axi.ARREADY && n < 2000) begin @(negedge clk); n++; end
    if (!axi.ARREADY) check("ar_timeout", 64'(axi.ARREADY), 64'd1);
    @(posedge clk); #1;
    axi.ARVALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r.size() != 0 || exp_m.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (exp_r.size() != 0 || exp_m.size() != 0) check("drain_timeout", 64'(exp_r.size() + exp_m.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       tog = 1'b1;
      1:       tog = ~tog;
      default: tog = 1'($urandom_range(0, 1));
    endcase
    axi.RREADY = tog && (hs_count < hs_limit);
  end

  // Monitor: latency, mem requests, R beats and hold-stability against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      prev_valid = 1'b0;
      hold_pend  = 1'b0;
    end else begin
      if (axi.ARVALID && axi.ARREADY) ref_cyc = cyc;
      if (axi.RVALID && !prev_valid) check("r_latency", 64'(cyc - ref_cyc), 64'(3 + LAT));
      if (hold_pend) begin
        check("r_hold_valid", 64'(axi.RVALID), 64'd1);
        check("r_hold_data", axi.RDATA, held_data);
        check("r_hold_ctl", 64'({axi.RID, axi.RRESP, axi.RLAST}), 64'(held_ctl));
      end
      if (mem_ren) begin
        if (exp_m.size() == 0) check("mem_extra", 64'(exp_m.size()), 64'd1);
        else                   check("mem_raddr", mem_raddr, exp_m.pop_front());
      end
      if (axi.RVALID && axi.RREADY) begin
        check("arready_busy", 64'(axi.ARREADY), 64'd0);
        if (exp_r.size() == 0) check("r_extra", 64'(exp_r.size()), 64'd1);
        else begin
          mon_b = exp_r.pop_front();
          check("rid", 64'(axi.RID), 64'(mon_b.id));
          check("rdata", axi.RDATA, mon_b.data);
          check("rresp", 64'(axi.RRESP), 64'(mon_b.resp));
          check("rlast", 64'(axi.RLAST), 64'(mon_b.last));
        end
        hs_count++;
        if (!axi.RLAST) ref_cyc = cyc;
      end
      hold_pend  = axi.RVALID && !axi.RREADY;
      held_data  = axi.RDATA;
      held_ctl   = {axi.RID, axi.RRESP, axi.RLAST};
      prev_valid = axi.RVALID;
    end
  end

  initial begin
    int n;
    axi.ARVALID = 1'b0; axi.ARID = 4'd0; axi.ARADDR = 64'd0; axi.ARLEN = 8'd0;
    axi.ARSIZE = 3'd0; axi.ARBURST = 2'd0; axi.ARPORT = 3'd0; axi.RREADY = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_arready", 64'(axi.ARREADY), 64'd0);
    check("rst_rvalid", 64'(axi.RVALID), 64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_rdata", axi.RDATA, 64'd0);
    #2 rstn = 1'b1;
    #1 check("arready_pre_edge", 64'(axi.ARREADY), 64'd0);
    @(posedge clk); #1;
    check("arready_post_edge", 64'(axi.ARREADY), 64'd1);

    rdy_mode = 0;
    send_ar(4'd3, 64'h8000_0000, 8'd0, 3'd3, 2'b01);
    drain();

    rdy_mode = 1;
    send_ar(4'd1, 64'h8000_0010, 8'd3, 3'd2, 2'b01);
    drain();

    rdy_mode = 0;
    send_ar(4'd2, 64'h0000_1000, 8'd1, 3'd3, 2'b01);
    drain();

    // Back-to-back ARs: later ones stay pending until the slave is idle.
    send_ar(4'd4, 64'h8000_0FF8, 8'd1, 3'd3, 2'b01);
    send_ar(4'd5, 64'h8000_0000, 8'd0, 3'd4, 2'b01);
    send_ar(4'd6, 64'h8000_0010, 8'd3, 3'd3, 2'b10);
    send_ar(4'd7, 64'h8000_0000, 8'd1, 3'd3, 2'b11);
    send_ar(4'd8, 64'h8000_0100, 8'd2, 3'd3, 2'b00);
    drain();

    send_ar(4'd9,  HI - 64'd7, 8'd0, 3'd3, 2'b01);
    send_ar(4'd10, LO - 64'd8, 8'd0, 3'd3, 2'b01);
    send_ar(4'd11, HI + 64'd1, 8'd0, 3'd3, 2'b00);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 8; i++)
      send_ar(4'($urandom_range(0, 15)), LO + 64'($urandom_range(0, 16383)),
              8'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 1)));
    drain();

    // Reset while beat 2 of an 8-beat burst is waiting in RESP.
    rdy_mode = 0;
    hs_limit = hs_count + 1;
    send_ar(4'd12, 64'h8000_0200, 8'd7, 3'd3, 2'b01);
    n = 0;
    while (!(axi.RVALID && hs_count == hs_limit) && n < 200) begin @(negedge clk); n++; end
    check("rst_setup_beat2", 64'(axi.RVALID && hs_count == hs_limit), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(axi.RVALID), 64'd0);
    check("mid_rst_arready", 64'(axi.ARREADY), 64'd0);
    check("mid_rst_rid", 64'(axi.RID), 64'd0);
    check("mid_rst_rdata", axi.RDATA, 64'd0);
    check("mid_rst_ctl", 64'({axi.RRESP, axi.RLAST}), 64'd0);
    check("mid_rst_mem", 64'(mem_ren) | mem_raddr, 64'd0);
    exp_r.delete();
    exp_m.delete();
    hs_limit = 1 << 30;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    #1 check("rel_arready_pre", 64'(axi.ARREADY), 64'd0);
    @(posedge clk); #1;
    check("rel_arready_post", 64'(axi.ARREADY), 64'd1);
    check("rel_rvalid", 64'(axi.RVALID), 64'd0);
    send_ar(4'd13, 64'h8000_0040, 8'd2, 3'd3, 2'b01);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_slave.md
AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 Parameter ADDR_LO, default 64'h0000_0000_8000_0000, lowest decoded byte address (inclusive).
REQ-002 Parameter ADDR_HI, default 64'h0000_0000_87FF_FFFF, highest decoded byte address (inclusive).
REQ-003 Parameter RD_LAT, default 0, extra wait cycles before each memory read (0..15).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 ARID  in  4 / ARADDR  in  64 / ARLEN  in  8 / ARSIZE  in  3 / ARBURST  in  2 / ARPORT  in  3: AXI read-address payload; ARPORT is accepted and ignored.
REQ-007 ARVALID  in  1, ARREADY  out  1: read-address handshake.
REQ-008 RID  out  4 / RDATA  out  64 / RRESP  out  2 / RLAST  out  1: read-data payload.
REQ-009 RVALID  out  1, RREADY  in  1: read-data handshake.
REQ-010 mem_ren  out  1 / mem_raddr  out  64: synchronous memory read request, one-cycle pulse.
REQ-011 mem_rdata  in  64: memory data, valid the cycle after mem_ren.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, READ, CAPT and RESP; only one burst is outstanding at a time.
REQ-013 IDLE: ARREADY=1 and all other outputs are held at their reset values; an AR handshake captures ARID, ARADDR, ARLEN, ARSIZE and ARBURST, then moves to WAIT if RD_LAT>0, else to READ.
REQ-014 ARREADY SHALL be 0 in every state except IDLE.
REQ-015 WAIT counts RD_LAT cycles, then moves to READ.
REQ-016 READ: for an OKAY beat, mem_ren=1 for exactly one cycle with mem_raddr = beat address with bits [2:0] cleared; for an error beat, mem_ren=0. Next state is CAPT.
REQ-017 CAPT: on the clock edge, RDATA<=mem_rdata (or 0 for an error beat), RRESP is loaded, RLAST<=(beat==ARLEN), RID<=captured ARID, and RVALID<=1. Next state is RESP.
REQ-018 Latency: with the AR handshake in cycle 0, the first RVALID SHALL be high in cycle 3+RD_LAT; each later beat follows the same 3+RD_LAT spacing after the previous R handshake.
REQ-019 RESP: RVALID and all R payload SHALL stay stable until RREADY=1.
REQ-020 On the R handshake, the last beat returns the FSM to IDLE and clears RVALID; any other beat increments the beat count, advances the address and goes to WAIT or READ.
REQ-021 Address advance: INCR (ARBURST=01) adds 1<<ARSIZE; FIXED (00) keeps the address; arithmetic is 64-bit and wraps modulo 2^64.
REQ-022 Burst length: ARLEN+1 beats, 1..256; the beat counter is 8 bits.
REQ-023 SLVERR (2'b10) SHALL apply to every beat of a burst when ARSIZE>3, when ARBURST=11, or when an INCR burst crosses a 4 KB boundary; this is decided at AR acceptance.
REQ-024 DECERR (2'b11) SHALL apply per beat when the beat address is outside [ADDR_LO, ADDR_HI]; SLVERR takes priority over DECERR.
REQ-025 Error beats SHALL return RDATA=0 and the full ARLEN+1 beat count.
REQ-026 An ARVALID arriving while the block is not in IDLE SHALL be left pending, not dropped, and is accepted on the first IDLE cycle.

Reset
REQ-027 rstn low SHALL immediately force the state to IDLE and, in the same cycle, set ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, mem_ren=0, mem_raddr=0, and clear all counters.
REQ-028 ARREADY SHALL go to 1 on the first rising clk edge after rstn deasserts.
REQ-029 A reset during a burst SHALL abandon the burst with no further beats issued.

Configuration
REQ-030 With AXI_RD_SLV_WRAP_EN defined, WRAP bursts (ARBURST=10) SHALL be OKAY for ARLEN in {1,3,7,15}: the address wraps within an (ARLEN+1)<<ARSIZE aligned window, and the 4 KB check is not applied.
REQ-031 A WRAP burst with an unaligned ARADDR or any other ARLEN SHALL return SLVERR.
REQ-032 Without AXI_RD_SLV_WRAP_EN, ARBURST=10 SHALL be treated as reserved and return SLVERR.

Verification
REQ-033 RD_LAT=0, AR {ID=3, ADDR=0x80000000, LEN=0, SIZE=3, INCR}, RREADY=1 -> mem_ren in cycle 1 at 0x80000000; RVALID in cycle 3 with RID=3, RLAST=1, RRESP=0, RDATA=memory word.
REQ-034 RD_LAT=2, INCR LEN=3 SIZE=2 at 0x80000010, RREADY toggling 1/0 -> four beats at mem_raddr 0x80000010,0x80000010,0x80000018,0x80000018; payload stable while RREADY=0; RLAST only on beat 4.
REQ-035 AR at 0x00001000 LEN=1 -> two beats, RRESP=11 and RDATA=0 on both, mem_ren never asserted.
REQ-036 INCR at 0x80000FF8 LEN=1 SIZE=3 -> SLVERR on both beats; ARSIZE=4 -> SLVERR; ARBURST=10 -> SLVERR without the macro; with AXI_RD_SLV_WRAP_EN, WRAP LEN=3 SIZE=3 at 0x80000010 -> addresses 0x10,0x18,0x00,0x08 (+0x80000000), all OKAY.
REQ-037 rstn pulled low while beat 2 of a LEN=7 burst is in RESP -> RVALID=0 in the same cycle; after release, ARREADY=1 and a new burst completes normally.
